// File: rtl/proc_trace_pkg.sv
// rtl/proc_trace_pkg.sv - shared types and constants for the processor trace FIFO
package proc_trace_pkg;

    localparam int DROP_CNT_W = 16;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] inst;
        logic [31:0] data;
    } trace_rec_t;

endpackage

// File: rtl/proc_trace_fifo_mem.sv
// rtl/proc_trace_fifo_mem.sv - DEPTH x 96 register file, one write port, one async read port
module proc_trace_fifo_mem
    import proc_trace_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int RW = $bits(trace_rec_t)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [RW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [RW-1:0] rdata
);

    logic [RW-1:0] mem [DEPTH];

    // Storage is not reset: contents are only meaningful behind valid occupancy.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/proc_trace_fifo.sv
// rtl/proc_trace_fifo.sv - retirement trace FIFO with drop and retire statistics
module proc_trace_fifo
    import proc_trace_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  trace_val,
    input  logic [31:0]           trace_addr,
    input  logic [31:0]           trace_inst,
    input  logic [31:0]           trace_data,
    input  logic                  clear,
    output logic                  out_val,
    input  logic                  out_rdy,
    output logic [31:0]           out_addr,
    output logic [31:0]           out_inst,
    output logic [31:0]           out_data,
    output logic [AW:0]           count,
    output logic                  overflow,
    output logic [DROP_CNT_W-1:0] drop_cnt,
    output logic [31:0]           retire_cnt
);

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          pop;
    logic          push;
    logic          drop;
    trace_rec_t    wr_rec;
    trace_rec_t    rd_rec;

    // Handshake: a full FIFO still accepts a record when the head leaves this cycle.
    assign out_val = (count != '0);
    assign full    = (count == FULL_CNT);
    assign pop     = out_val && out_rdy;
    assign push    = trace_val && (!full || pop);
    assign drop    = trace_val && !push;

    assign wr_rec.addr = trace_addr;
    assign wr_rec.inst = trace_inst;
    assign wr_rec.data = trace_data;

    assign out_addr = rd_rec.addr;
    assign out_inst = rd_rec.inst;
    assign out_data = rd_rec.data;

    proc_trace_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wr_rec),
        .raddr (rd_ptr),
        .rdata (rd_rec)
    );

    // Pointers wrap naturally at DEPTH; occupancy tells full from empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Statistics: clear wins over any same-cycle increment; drop count saturates.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt   <= '0;
            overflow   <= 1'b0;
            retire_cnt <= '0;
        end else if (clear) begin
            drop_cnt   <= '0;
            overflow   <= 1'b0;
            retire_cnt <= '0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != '1) begin
                    drop_cnt <= drop_cnt + 1'b1;
                end
            end
            if (trace_val) begin
                retire_cnt <= retire_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_proc_trace_fifo.sv
// tb/tb_proc_trace_fifo.sv - self-checking bench for proc_trace_fifo against a queue model
module tb_proc_trace_fifo;

    localparam int DEPTH = 8;

    logic        clk;
    logic        rst;
    logic        trace_val;
    logic [31:0] trace_addr;
    logic [31:0] trace_inst;
    logic [31:0] trace_data;
    logic        clear;
    logic        out_val;
    logic        out_rdy;
    logic [31:0] out_addr;
    logic [31:0] out_inst;
    logic [31:0] out_data;
    logic [3:0]  count;
    logic        overflow;
    logic [15:0] drop_cnt;
    logic [31:0] retire_cnt;

    int total = 0;
    int bad   = 0;

    logic [95:0] mq[$];
    logic [15:0] m_drop;
    logic        m_ovf;
    logic [31:0] m_ret;

    proc_trace_fifo #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .trace_val  (trace_val),
        .trace_addr (trace_addr),
        .trace_inst (trace_inst),
        .trace_data (trace_data),
        .clear      (clear),
        .out_val    (out_val),
        .out_rdy    (out_rdy),
        .out_addr   (out_addr),
        .out_inst   (out_inst),
        .out_data   (out_data),
        .count      (count),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt),
        .retire_cnt (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        mq.delete();
        m_drop = '0;
        m_ovf  = 1'b0;
        m_ret  = '0;
    endtask

    // Drive one cycle of stimulus, advance the model, and return #1 after the edge.
    task automatic drive(input bit v, input logic [31:0] a, input logic [31:0] i,
                         input logic [31:0] d, input bit rdy, input bit clr);
        bit do_pop;
        bit do_push;
        @(negedge clk);
        trace_val  = v;
        trace_addr = a;
        trace_inst = i;
        trace_data = d;
        out_rdy    = rdy;
        clear      = clr;
        do_pop  = (mq.size() != 0) && rdy;
        do_push = v && ((mq.size() < DEPTH) || do_pop);
        if (do_pop) void'(mq.pop_front());
        if (do_push) mq.push_back({trace_addr, trace_inst, trace_data});
        if (clr) begin
            m_drop = '0;
            m_ovf  = 1'b0;
            m_ret  = '0;
        end else begin
            if (v && !do_push) begin
                m_ovf = 1'b1;
                if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
            end
            if (v) m_ret = m_ret + 32'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; trace_val = 0; trace_addr = 0; trace_inst = 0; trace_data = 0;
        clear = 0; out_rdy = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        total++; if (out_val !== 1'b0) begin bad++; $display("FAIL reset_out_val: got %b want 0", out_val); end
        total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
        total++; if ({overflow, drop_cnt, retire_cnt} !== 49'd0) begin bad++;
            $display("FAIL reset_stats: got ovf=%b drop=%0d ret=%0d want zeros", overflow, drop_cnt, retire_cnt); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_single();
        drive(1, 32'h200, 32'h00b51463, 'x, 0, 0);
        total++; if (out_val !== 1'b1) begin bad++; $display("FAIL single_val: got %b want 1", out_val); end
        total++; if (out_addr !== 32'h200) begin bad++; $display("FAIL single_addr: got %h want 00000200", out_addr); end
        total++; if (out_inst !== 32'h00b51463) begin bad++; $display("FAIL single_inst: got %h want 00b51463", out_inst); end
        total++; if (out_data !== mq[0][31:0]) begin bad++; $display("FAIL single_data: got %h want %h", out_data, mq[0][31:0]); end
        total++; if (count !== 4'd1) begin bad++; $display("FAIL single_count: got %0d want 1", count); end
        drive(0, 0, 0, 0, 1, 0);
        total++; if (count !== 4'd0 || out_val !== 1'b0) begin bad++;
            $display("FAIL single_pop: got count=%0d val=%b want 0 0", count, out_val); end
    endtask

    task automatic test_fill();
        drive(0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 10; k++) drive(1, 32'h200 + 32'(4 * k), $urandom, $urandom, 0, 0);
        total++; if (count !== 4'd8) begin bad++; $display("FAIL fill_count: got %0d want 8", count); end
        total++; if (drop_cnt !== 16'd2) begin bad++; $display("FAIL fill_drop: got %0d want 2", drop_cnt); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL fill_ovf: got %b want 1", overflow); end
        total++; if (retire_cnt !== 32'd10) begin bad++; $display("FAIL fill_retire: got %0d want 10", retire_cnt); end
        for (int k = 0; k < 8; k++) begin
            total++; if (out_addr !== 32'h200 + 32'(4 * k)) begin bad++;
                $display("FAIL fill_order[%0d]: got %h want %h", k, out_addr, 32'h200 + 32'(4 * k)); end
            drive(0, 0, 0, 0, 1, 0);
        end
        total++; if (count !== 4'd0) begin bad++; $display("FAIL fill_drained: got %0d want 0", count); end
    endtask

    task automatic test_full_pop();
        logic [95:0] head;
        for (int k = 0; k < 8; k++) drive(1, 32'h1000 + 32'(4 * k), $urandom, $urandom, 0, 0);
        for (int k = 0; k < 20; k++) begin
            head = mq[0];
            total++; if ({out_addr, out_inst, out_data} !== head) begin bad++;
                $display("FAIL fullpop_head[%0d]: got %h want %h", k, {out_addr, out_inst, out_data}, head); end
            drive(1, 32'h2000 + 32'(4 * k), $urandom, $urandom, 1, 0);
            total++; if (count !== 4'd8 || drop_cnt !== 16'd2) begin bad++;
                $display("FAIL fullpop_cnt[%0d]: got count=%0d drop=%0d want 8 2", k, count, drop_cnt); end
        end
    endtask

    task automatic test_stall();
        logic [95:0] head;
        repeat (5) drive(0, 0, 0, 0, 1, 0);
        head = mq[0];
        for (int k = 0; k < 5; k++) begin
            drive(1, $urandom, $urandom, $urandom, 0, 0);
            total++; if ({out_addr, out_inst, out_data} !== head) begin bad++;
                $display("FAIL stall_hold[%0d]: got %h want %h", k, {out_addr, out_inst, out_data}, head); end
            total++; if (count !== 4'(4 + k)) begin bad++; $display("FAIL stall_count[%0d]: got %0d want %0d", k, count, 4 + k); end
        end
    endtask

    task automatic test_clear();
        drive(1, $urandom, $urandom, $urandom, 0, 1);
        total++; if ({overflow, drop_cnt, retire_cnt} !== 49'd0) begin bad++;
            $display("FAIL clear_stats: got ovf=%b drop=%0d ret=%0d want zeros", overflow, drop_cnt, retire_cnt); end
        total++; if (count !== 4'd8) begin bad++; $display("FAIL clear_count: got %0d want 8", count); end
    endtask

    task automatic test_reset_mid();
        repeat (3) drive(0, 0, 0, 0, 1, 0);
        total++; if (count !== 4'd5) begin bad++; $display("FAIL rstmid_pre: got %0d want 5", count); end
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        total++; if (out_val !== 1'b0 || count !== 4'd0) begin bad++;
            $display("FAIL rstmid_async: got val=%b count=%0d want 0 0", out_val, count); end
        @(negedge clk);
        rst = 1'b1;
        drive(1, 32'hABC0, 32'h12345678, 32'h9, 0, 0);
        total++; if (count !== 4'd1 || out_addr !== 32'hABC0 || retire_cnt !== 32'd1) begin bad++;
            $display("FAIL rstmid_fresh: got count=%0d addr=%h ret=%0d want 1 0000abc0 1", count, out_addr, retire_cnt); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            drive(($urandom % 4) != 0, $urandom, $urandom, $urandom,
                  ($urandom % 3) == 0, ($urandom % 50) == 0);
            total++; if (count !== 4'(mq.size()) || out_val !== (mq.size() != 0)) begin bad++;
                $display("FAIL rand_occ[%0d]: got count=%0d val=%b want %0d", k, count, out_val, mq.size()); end
            if (mq.size() != 0) begin
                total++; if ({out_addr, out_inst, out_data} !== mq[0]) begin bad++;
                    $display("FAIL rand_head[%0d]: got %h want %h", k, {out_addr, out_inst, out_data}, mq[0]); end
            end
            total++; if (drop_cnt !== m_drop || overflow !== m_ovf || retire_cnt !== m_ret) begin bad++;
                $display("FAIL rand_stats[%0d]: got drop=%0d ovf=%b ret=%0d want %0d %b %0d",
                         k, drop_cnt, overflow, retire_cnt, m_drop, m_ovf, m_ret); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_full_pop();
        test_stall();
        test_clear();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/proc_trace_fifo.md
# proc_trace_fifo

Captures the per-instruction retirement trace (address, instruction word, writeback data) emitted by the TinyRV1 processor and buffers it in a DEPTH-entry FIFO. A downstream consumer (bench checker, debug UART, or logic analyser port) drains it through a valid/ready handshake. Sits directly downstream of the processor's `trace_*` outputs. Also keeps retire and drop statistics, so bursts of single-cycle retirements are never silently lost.

## Interface
- `DEPTH`, 8, FIFO entries; power of two, ≥ 2
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `trace_val`  in  1  retirement record valid this cycle
- `trace_addr`  in  32  PC of retired instruction
- `trace_inst`  in  32  instruction word
- `trace_data`  in  32  writeback data; may be X for branches/stores, stored verbatim
- `clear`  in  1  synchronous clear of statistics only
- `out_val`  out  1  head entry valid
- `out_rdy`  in  1  consumer accepts head
- `out_addr`, `out_inst`, `out_data`  out  32 each  head entry fields
- `count`  out  $clog2(DEPTH)+1  current occupancy
- `overflow`  out  1  sticky: at least one record dropped
- `drop_cnt`  out  16  dropped records, saturating at 0xFFFF
- `retire_cnt`  out  32  total `trace_val` pulses seen, wrapping

## Operation
- Push: on `trace_val`=1, record is written if `count < DEPTH`, or if `count == DEPTH` and a pop happens in the same cycle.
- Drop: otherwise the record is discarded. `drop_cnt` increments (saturating) and `overflow` sets.
- Pop: when `out_val && out_rdy`, head advances. `out_*` are driven from storage at the read pointer and must be stable while `out_val && !out_rdy`.
- Pointers: read and write pointers are $clog2(DEPTH) bits, wrap modulo DEPTH. The full/empty distinction comes from `count`.
- Occupancy: `count` updates by +1 (push only), −1 (pop only), or 0 (both or neither).
- `retire_cnt` increments on every `trace_val`, whether the record is accepted or dropped.
- `clear`=1: zeroes `drop_cnt`, `overflow`, and `retire_cnt` at the next edge. It has priority over a same-cycle increment. FIFO contents and pointers are untouched.
- Reset (`rst`=0, any time, including mid-burst): `out_val`=0, `count`=0, pointers=0, `overflow`=0, `drop_cnt`=0, `retire_cnt`=0 immediately. Storage contents are don't-care.

## Timing
- Write latency: a record pushed at edge N is visible on `out_*` with `out_val`=1 after edge N. `out_val` is combinational from `count != 0`; there is no fall-through in the same cycle.
- Pop: occurs at the edge where `out_val && out_rdy`. The next entry appears after that edge.
- Throughput: one push and one pop per cycle, sustained indefinitely at any occupancy.
- Empty + push + `out_rdy`=1: no pop that cycle because `out_val`=0. The entry appears next cycle.
- Full + push + pop: both happen, `count` stays DEPTH, no drop.
- Statistics outputs are registered and reflect events up to the previous edge.

## Structure
- Shared package `proc_trace_pkg`:
  - `trace_rec_t` packed struct {addr, inst, data}, 96 bits
  - `DROP_CNT_W` = 16 constant
- One natural sub-module: `proc_trace_fifo_mem`, a DEPTH×96 register-file storage with a single write port and a single asynchronous read port.
- The top level holds pointers, occupancy, handshake, and statistics. Target size is ~150–200 lines of RTL total.

## Test plan
- Single record: push {0x200, bne inst, X} with `out_rdy`=0.
  - Next cycle: `out_val`=1, `out_addr`=0x200, `count`=1.
  - Assert `out_rdy`: `count`=0 after the edge.
- Fill: DEPTH=8, push 10 consecutive records (addr 0x200+4i) with `out_rdy`=0.
  - `count`=8, `drop_cnt`=2, `overflow`=1, `retire_cnt`=10.
  - Draining yields addr 0x200…0x21C in order.
- Full with simultaneous pop: at `count`=8, push and pop together for 20 cycles.
  - `count` stays 8, `drop_cnt` unchanged, output order preserved across pointer wrap.
- Stalled consumer: with `out_rdy` held 0 for 5 cycles, `out_*` hold the same values; push during that time grows `count`.
- Clear vs. drop: `clear`=1 in the same cycle as a dropped push.
  - After the edge, `drop_cnt`=0, `overflow`=0, `retire_cnt`=0, `count` unchanged.
- Reset mid-burst: assert `rst`=0 between edges with `count`=5.
  - `out_val`=0 and `count`=0 before the next edge.
  - After release, a fresh push appears as the sole entry.
